// File: rtl/lut_vec_sequencer.sv
// lut_vec_sequencer: time-shares one scalar LUT across all lanes of a vector op
//   clk, rst_n               clock, asynchronous active-low reset
//   start_valid/start_ready  vector op handshake, idx_vec sampled at accept
//   lut_req/lut_idx          one index per cycle to the shared LUT
//   lut_data                 LUT result, valid LUT_LAT cycles after lut_req
//   res_valid/res_ready      result handshake, res_vec held stable while waiting
//   busy                     high whenever the sequencer is not idle
module lut_vec_sequencer #(
   parameter int LANES   = 4,
   parameter int IDX_W   = 8,
   parameter int DATA_W  = 32,
   parameter int LUT_LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_valid,
   output logic                    start_ready,
   input  logic [LANES*IDX_W-1:0]  idx_vec,
   output logic                    lut_req,
   output logic [IDX_W-1:0]        lut_idx,
   input  logic [DATA_W-1:0]       lut_data,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [LANES*DATA_W-1:0] res_vec,
   output logic                    busy
);
   localparam int TW = $clog2(LANES);
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
   logic [1:0]             state, state_n;
   logic [LANES*IDX_W-1:0] idx_reg;
   logic [TW-1:0]          cnt;
   logic [LUT_LAT-1:0]     pv;
   logic [TW-1:0]          pt [LUT_LAT];
   logic [LANES-1:0]       written, written_n;
   logic                   last, cap;
   logic [TW-1:0]          cap_tag;
   assign start_ready = state == IDLE;
   assign busy        = state != IDLE;
   assign res_valid   = state == DONE;
   assign lut_req     = state == ISSUE;
   assign lut_idx     = lut_req ? idx_reg[cnt*IDX_W +: IDX_W] : '0;
   assign last        = cnt == TW'(LANES - 1);
   assign cap_tag     = pt[LUT_LAT-1];
   // a slot already filled in this op is never overwritten
   assign cap         = pv[LUT_LAT-1] && !written[cap_tag];
   assign written_n   = cap ? written | (LANES'(1) << cap_tag) : written;
   assign state_n = (state == IDLE)  ? (start_valid ? ISSUE : IDLE) :
                    (state == ISSUE) ? (last ? DRAIN : ISSUE) :
                    (state == DRAIN) ? (&written_n ? DONE : DRAIN) :
                                       (res_ready ? IDLE : DONE);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx_reg <= '0;
         cnt     <= '0;
         res_vec <= '0;
         written <= '0;
         pv      <= '0;
         for (int i = 0; i < LUT_LAT; i++) pt[i] <= '0;
      end else begin
         state   <= state_n;
         written <= written_n;
         // tag pipe mirrors the LUT latency so each result lands in its own lane
         pv[0]   <= lut_req;
         pt[0]   <= cnt;
         for (int i = 1; i < LUT_LAT; i++) begin
            pv[i] <= pv[i-1];
            pt[i] <= pt[i-1];
         end
         if (cap) res_vec[cap_tag*DATA_W +: DATA_W] <= lut_data;
         if (lut_req && !last) cnt <= cnt + 1'b1;
         if (start_ready && start_valid) begin
            idx_reg <= idx_vec;
            res_vec <= '0;
            written <= '0;
            cnt     <= '0;
         end
      end
   end
endmodule

// File: tb/tb_lut_vec_sequencer.sv
// tb_lut_vec_sequencer: checks lut_vec_sequencer at LUT_LAT 1 and 3 against a cycle-timing model
module tb_lut_vec_sequencer;
   localparam int L = 4;
   localparam logic [31:0] C = 32'h3F576AA4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   logic        sv [2];
   logic        rr [2];
   logic [31:0] iv [2];
   logic        sr [2];
   logic        req [2];
   logic        rv [2];
   logic        bz [2];
   logic [7:0]  li [2];
   logic [127:0] rvec [2];
   logic [31:0] d0;
   logic [31:0] d1 [3];
   int n_cmp = 0;
   int n_bad = 0;
   bit run = 0;
   lut_vec_sequencer #(.LANES(4), .IDX_W(8), .DATA_W(32), .LUT_LAT(1)) u0 (
      .clk(clk), .rst_n(rst_n), .start_valid(sv[0]), .start_ready(sr[0]), .idx_vec(iv[0]),
      .lut_req(req[0]), .lut_idx(li[0]), .lut_data(d0), .res_valid(rv[0]), .res_ready(rr[0]),
      .res_vec(rvec[0]), .busy(bz[0]));
   lut_vec_sequencer #(.LANES(4), .IDX_W(8), .DATA_W(32), .LUT_LAT(3)) u1 (
      .clk(clk), .rst_n(rst_n), .start_valid(sv[1]), .start_ready(sr[1]), .idx_vec(iv[1]),
      .lut_req(req[1]), .lut_idx(li[1]), .lut_data(d1[2]), .res_valid(rv[1]), .res_ready(rr[1]),
      .res_vec(rvec[1]), .busy(bz[1]));
   function automatic logic [31:0] f(input logic [7:0] i);
      return (i == 8'd1) ? C : 32'h0;
   endfunction
   function automatic int lat(input int d);
      return d ? 3 : 1;
   endfunction
   // LUT models: random garbage whenever no request was made
   always @(posedge clk) d0 <= req[0] ? f(li[0]) : $urandom;
   always @(posedge clk) begin
      d1[0] <= req[1] ? f(li[1]) : $urandom;
      d1[1] <= d1[0];
      d1[2] <= d1[1];
   end
   // timing model: k counts cycles since accept, results due at k = L+lat+1
   bit           idle [2];
   int           k [2];
   logic [31:0]  mi [2];
   logic [127:0] mev [2];
   logic [127:0] mrv [2];
   bit           known [2];
   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            idle[d] = 1; k[d] = 0; known[d] = 1; mrv[d] = '0;
         end else if (idle[d]) begin
            if (sv[d]) begin
               idle[d] = 0; k[d] = 1; mi[d] = iv[d]; known[d] = 0;
               for (int j = 0; j < L; j++) mev[d][j*32 +: 32] = f(iv[d][j*8 +: 8]);
            end
         end else if (k[d] == L + lat(d) + 1) begin
            if (rr[d]) idle[d] = 1;
         end else begin
            k[d]++;
            if (k[d] == L + lat(d) + 1) begin
               known[d] = 1; mrv[d] = mev[d];
            end
         end
      end
   end
   task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask
   always @(negedge clk) if (run) begin
      for (int d = 0; d < 2; d++) begin
         logic er;
         er = !idle[d] && k[d] >= 1 && k[d] <= L;
         chk($sformatf("u%0d.start_ready", d), sr[d], idle[d]);
         chk($sformatf("u%0d.busy", d), bz[d], !idle[d]);
         chk($sformatf("u%0d.lut_req", d), req[d], er);
         chk($sformatf("u%0d.lut_idx", d), li[d], er ? mi[d][(k[d]-1)*8 +: 8] : 8'h0);
         chk($sformatf("u%0d.res_valid", d), rv[d], !idle[d] && k[d] == L + lat(d) + 1);
         if (known[d]) chk($sformatf("u%0d.res_vec", d), rvec[d], mrv[d]);
      end
   end
   task automatic run_op(input int d, input logic [31:0] idx, output int c, output logic [31:0] seen);
      iv[d] = idx; sv[d] = 1;
      @(posedge clk); #2;
      sv[d] = 0; c = 0; seen = '0;
      do begin
         @(negedge clk);
         c++;
         if (c <= 4) seen[(c-1)*8 +: 8] = li[d];
      end while (!rv[d] && c < 40);
   endtask
   task automatic finish_op(input int d);
      rr[d] = 1;
      @(posedge clk); #2;
      rr[d] = 0;
   endtask
   initial begin
      int c, v1, v2;
      logic [31:0] seen;
      logic [127:0] r1, r2;
      sv[0] = 0; sv[1] = 0; rr[0] = 0; rr[1] = 0; iv[0] = '0; iv[1] = '0;
      v1 = 0; v2 = 0; r1 = '0; r2 = '0;
      repeat (2) @(posedge clk);
      run = 1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("t1_start_ready", sr[d], 1'b1);
         chk("t1_busy", bz[d], 1'b0);
         chk("t1_res_valid", rv[d], 1'b0);
         chk("t1_lut_req", req[d], 1'b0);
         chk("t1_res_vec", rvec[d], 128'h0);
      end
      @(posedge clk); #2 rst_n = 1;
      @(posedge clk); #2;
      run_op(0, 32'h00010001, c, seen);
      chk("t2_valid_cycle", c, 6);
      chk("t2_lut_idx_seq", seen, 32'h00010001);
      chk("t2_res_vec", rvec[0], {32'h0, C, 32'h0, C});
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #2;
         sv[0] = (i == 3);
         @(negedge clk);
         chk("t3_res_vec_stable", rvec[0], {32'h0, C, 32'h0, C});
         chk("t3_start_ready", sr[0], 1'b0);
         chk("t3_res_valid", rv[0], 1'b1);
      end
      finish_op(0);
      @(negedge clk);
      chk("t3_idle_start_ready", sr[0], 1'b1);
      chk("t3_idle_res_valid", rv[0], 1'b0);
      @(posedge clk); #2;
      run_op(1, 32'h01010101, c, seen);
      chk("t4_valid_cycle", c, 8);
      chk("t4_lut_idx_seq", seen, 32'h01010101);
      chk("t4_res_vec", rvec[1], {C, C, C, C});
      finish_op(1);
      iv[0] = 32'h01010101; sv[0] = 1;
      @(posedge clk); #2 sv[0] = 0;
      @(posedge clk); #2;
      @(posedge clk); #2 rst_n = 0;
      @(negedge clk);
      chk("t5_reset_res_vec", rvec[0], 128'h0);
      chk("t5_reset_lut_req", req[0], 1'b0);
      chk("t5_reset_start_ready", sr[0], 1'b1);
      @(posedge clk); #2 rst_n = 1;
      @(posedge clk); #2;
      run_op(0, 32'h00000000, c, seen);
      chk("t5_valid_cycle", c, 6);
      chk("t5_res_vec", rvec[0], 128'h0);
      finish_op(0);
      iv[0] = 32'h00000100; sv[0] = 1; rr[0] = 1;
      for (int n = 0; n <= 14; n++) begin
         @(negedge clk);
         if (n == 1) iv[0] = 32'h01000000;
         if (n == 8) sv[0] = 0;
         if (rv[0]) begin
            if (v1 == 0) begin v1 = n; r1 = rvec[0]; end
            else begin v2 = n; r2 = rvec[0]; end
         end
      end
      rr[0] = 0;
      chk("t6_first_done", v1, 6);
      chk("t6_second_done", v2, 13);
      chk("t6_first_vec", r1, {32'h0, 32'h0, C, 32'h0});
      chk("t6_second_vec", r2, {C, 32'h0, 32'h0, 32'h0});
      @(posedge clk); #2;
      @(negedge clk);
      run = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
